// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the line-level arbiter port and the beat-level
// physical memory port of the cache-line adaptor.
//
// Handshake: a line request (pmem_read_cla / pmem_write_cla) is held by
// the requester until pmem_resp_cla pulses for one cycle; on the memory
// side mem_read / mem_write stay high for the whole burst and each cycle
// with mem_resp=1 transfers exactly one beat, while mem_resp=0 cycles are
// wait states that move no data.
interface cacheline_adaptor_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    // Line side (arbiter)
    logic              pmem_read_cla;
    logic              pmem_write_cla;
    logic [31:0]       pmem_address_cla;
    logic [LINE_W-1:0] pmem_wdata_256_cla;
    logic              pmem_resp_cla;
    logic [LINE_W-1:0] pmem_rdata_256_cla;

    // Beat side (physical memory)
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [BEAT_W-1:0] mem_wdata;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_resp;

    // The adaptor: masters the memory burst, serves the arbiter.
    modport master (
        input  pmem_read_cla, pmem_write_cla, pmem_address_cla,
               pmem_wdata_256_cla, mem_rdata, mem_resp,
        output pmem_resp_cla, pmem_rdata_256_cla, mem_read, mem_write,
               mem_address, mem_wdata
    );

    // The environment: arbiter plus physical memory.
    modport slave (
        output pmem_read_cla, pmem_write_cla, pmem_address_cla,
               pmem_wdata_256_cla, mem_rdata, mem_resp,
        input  pmem_resp_cla, pmem_rdata_256_cla, mem_read, mem_write,
               mem_address, mem_wdata
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: turns one LINE_W-bit line read/write into a burst of
// BEATS = LINE_W/BEAT_W beats on the physical memory port. All outputs come
// from registers or are decoded from registered state only.
module cacheline_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_adaptor_if.master bus,
    output logic [1:0]          state_o
);
    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(LINE_W / 8);
    // Clears the byte-offset-within-line bits of a request address.
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] line_q, line_d;
    int                beat_base;

    // Bit offset of the current beat inside a line.
    assign beat_base = BEAT_W * int'(cnt_q);

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: read wins over write; DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.pmem_read_cla) begin
                    state_d = S_READ;
                end else if (bus.pmem_write_cla) begin
                    state_d = S_WRITE;
                end
            end
            S_READ, S_WRITE: begin
                if (bus.mem_resp && cnt_q == LAST_BEAT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: latch request in IDLE, advance one beat per mem_resp.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        line_d  = line_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.pmem_read_cla) begin
                    addr_d = bus.pmem_address_cla & ADDR_MASK;
                end else if (bus.pmem_write_cla) begin
                    addr_d  = bus.pmem_address_cla & ADDR_MASK;
                    wline_d = bus.pmem_wdata_256_cla;
                end
            end
            S_READ: begin
                if (bus.mem_resp) begin
                    line_d[beat_base +: BEAT_W] = bus.mem_rdata;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (bus.mem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            line_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            line_q  <= line_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.mem_read           = (state_q == S_READ);
        bus.mem_write          = (state_q == S_WRITE);
        bus.pmem_resp_cla      = (state_q == S_DONE);
        bus.mem_address        = addr_q;
        bus.pmem_rdata_256_cla = line_q;
        bus.mem_wdata          = '0;
        if (state_q == S_WRITE) begin
            bus.mem_wdata = wline_q[beat_base +: BEAT_W];
        end
        state_o = state_q;
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for the cache-line adaptor: a table of line transactions driven
// against a small memory responder, plus hand-written reset and idle cases.
module tb_cacheline_adaptor;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct {
        logic              is_read;
        logic              both;
        logic [31:0]       addr;
        logic [31:0]       exp_addr;
        logic [LINE_W-1:0] line;
        int                waits;      // wait states before each beat, -1 = random
        logic              drop;       // release request after first beat
        logic              hold_done;  // keep requests asserted through DONE
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_o;

    cacheline_adaptor_if #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

    cacheline_adaptor #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int                total = 0;
    int                bad   = 0;
    logic [BEAT_W-1:0] exp_q[$];       // write beats expected on mem_wdata
    logic [LINE_W-1:0] exp_line_q[$];  // lines expected on pmem_rdata
    logic [LINE_W-1:0] model_line;     // line pmem_rdata must hold
    txn_t              vec[8];

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic int pick_wait(input int w);
        return (w < 0) ? int'($urandom_range(0, 3)) : w;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_resp"},  bus.pmem_resp_cla, '0);
        check({tag, "_rw"},    {bus.mem_read, bus.mem_write}, '0);
        check({tag, "_addr"},  bus.mem_address, '0);
        check({tag, "_wdata"}, bus.mem_wdata, '0);
        check({tag, "_rdata"}, bus.pmem_rdata_256_cla, '0);
        check({tag, "_state"}, state_o, ST_IDLE);
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_txn(input txn_t t);
        int cyc, beat, stall, total_wait, this_wait;
        @(negedge clk);
        check("idle_state", state_o, ST_IDLE);
        check("idle_resp", bus.pmem_resp_cla, '0);
        check("idle_rw", {bus.mem_read, bus.mem_write}, '0);
        bus.mem_resp           = 1'b0;
        bus.pmem_read_cla      = t.is_read;
        bus.pmem_write_cla     = !t.is_read || t.both;
        bus.pmem_address_cla   = t.addr;
        bus.pmem_wdata_256_cla = t.is_read ? ~t.line : t.line;
        if (t.is_read) exp_line_q.push_back(t.line);
        else for (int b = 0; b < BEATS; b++) exp_q.push_back(t.line[b*BEAT_W +: BEAT_W]);
        beat = 0; stall = 0; total_wait = 0;
        this_wait = pick_wait(t.waits);
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (bus.pmem_resp_cla) begin
                check("latency", cyc, BEATS + 1 + total_wait);
                check("done_rw", {bus.mem_read, bus.mem_write}, '0);
                check("done_state", state_o, ST_DONE);
                if (t.is_read) begin
                    if (exp_line_q.size() > 0) check("read_line", bus.pmem_rdata_256_cla, exp_line_q.pop_front());
                    model_line = t.line;
                end else begin
                    check("rdata_kept", bus.pmem_rdata_256_cla, model_line);
                end
                bus.mem_resp  = 1'b1;            // must be ignored in DONE
                bus.mem_rdata = {$urandom, $urandom};
                if (!t.hold_done) begin
                    bus.pmem_read_cla  = 1'b0;
                    bus.pmem_write_cla = 1'b0;
                end
                return;
            end
            check("burst_rw", {bus.mem_read, bus.mem_write}, t.is_read ? 2'b10 : 2'b01);
            check("mem_address", bus.mem_address, t.exp_addr);
            if (!t.is_read) check("wr_keeps_line", bus.pmem_rdata_256_cla, model_line);
            if (beat >= BEATS) begin
                bus.mem_resp = 1'b0;
            end else if (stall < this_wait) begin
                stall++; total_wait++;
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = {$urandom, $urandom};
                if (!t.is_read && exp_q.size() > 0) check("wdata_stall", bus.mem_wdata, exp_q[0]);
            end else begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = t.line[beat*BEAT_W +: BEAT_W];
                if (!t.is_read && exp_q.size() > 0) check("wdata_beat", bus.mem_wdata, exp_q.pop_front());
                beat++; stall = 0;
                this_wait = pick_wait(t.waits);
                if (t.drop) begin
                    bus.pmem_read_cla  = 1'b0;
                    bus.pmem_write_cla = 1'b0;
                end
            end
        end
        check("timeout_no_resp", 1'b1, 1'b0);
        bus.mem_resp = 1'b0; bus.pmem_read_cla = 1'b0; bus.pmem_write_cla = 1'b0;
    endtask

    // mem_resp pulses while idle must not start or advance anything.
    task automatic idle_resp_test();
        @(negedge clk);
        bus.pmem_read_cla = 1'b0; bus.pmem_write_cla = 1'b0;
        bus.mem_resp = 1'b1; bus.mem_rdata = 64'hBADB_ADBA_DBAD_BADB;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_ign_state", state_o, ST_IDLE);
            check("idle_ign_rw", {bus.mem_read, bus.mem_write}, '0);
        end
        bus.mem_resp = 1'b0;
    endtask

    // Reset after two read beats: no response, outputs cleared.
    task automatic abort_test();
        @(negedge clk);
        bus.pmem_read_cla = 1'b1; bus.pmem_write_cla = 1'b0;
        bus.pmem_address_cla = 32'h0000_0500; bus.mem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_rw", {bus.mem_read, bus.mem_write}, 2'b10);
            bus.mem_resp = 1'b1; bus.mem_rdata = 64'hAAAA_AAAA_AAAA_AAA0 + 64'(i);
        end
        @(negedge clk);
        check("abort_pre_state", state_o, ST_READ);
        check("abort_pre_resp", bus.pmem_resp_cla, '0);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0; bus.pmem_read_cla = 1'b0; bus.mem_resp = 1'b0;
        model_line = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        txn_t fresh;
        bus.pmem_read_cla = 1'b0; bus.pmem_write_cla = 1'b0;
        bus.pmem_address_cla = '0; bus.pmem_wdata_256_cla = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0;
        model_line = '0;

        vec[0] = '{is_read:1'b1, both:1'b0, addr:32'h0000_1234, exp_addr:32'h0000_1220,
                   line:{64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                   waits:0, drop:1'b0, hold_done:1'b0};
        vec[1] = '{is_read:1'b0, both:1'b0, addr:32'h8000_0040, exp_addr:32'h8000_0040,
                   line:{64'hD3D3_0000_3333_D3D3, 64'hD2D2_0000_2222_D2D2,
                         64'hD1D1_0000_1111_D1D1, 64'hD0D0_0000_0000_D0D0},
                   waits:2, drop:1'b0, hold_done:1'b0};
        vec[2] = '{is_read:1'b1, both:1'b1, addr:32'hDEAD_BEEF, exp_addr:32'hDEAD_BEE0,
                   line:rand_line(), waits:1, drop:1'b0, hold_done:1'b1};
        vec[3] = '{is_read:1'b1, both:1'b0, addr:32'hFFFF_FFFF, exp_addr:32'hFFFF_FFE0,
                   line:rand_line(), waits:3, drop:1'b0, hold_done:1'b1};
        vec[4] = '{is_read:1'b0, both:1'b0, addr:32'h0000_003F, exp_addr:32'h0000_0020,
                   line:rand_line(), waits:0, drop:1'b1, hold_done:1'b0};
        vec[5] = '{is_read:1'b1, both:1'b0, addr:32'h1000_0007, exp_addr:32'h1000_0000,
                   line:rand_line(), waits:-1, drop:1'b1, hold_done:1'b0};
        vec[6] = '{is_read:1'b0, both:1'b0, addr:32'h2000_005A, exp_addr:32'h2000_0040,
                   line:rand_line(), waits:-1, drop:1'b0, hold_done:1'b0};
        vec[7] = '{is_read:1'b1, both:1'b0, addr:32'h7654_3210, exp_addr:32'h7654_3200,
                   line:rand_line(), waits:0, drop:1'b0, hold_done:1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        idle_resp_test();
        for (int i = 0; i < 8; i++) run_txn(vec[i]);

        abort_test();
        fresh = '{is_read:1'b1, both:1'b0, addr:32'h0000_0100, exp_addr:32'h0000_0100,
                  line:rand_line(), waits:1, drop:1'b0, hold_done:1'b0};
        run_txn(fresh);

        @(negedge clk);
        bus.pmem_read_cla = 1'b0; bus.pmem_write_cla = 1'b0; bus.mem_resp = 1'b0;
        @(negedge clk);
        check("end_state", state_o, ST_IDLE);
        check("end_line_held", bus.pmem_rdata_256_cla, model_line);
        check("end_wbeats_left", exp_q.size(), 0);
        check("end_lines_left", exp_line_q.size(), 0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache-line width in bits.
REQ-002 SHALL have parameter BEAT_W, default 64, memory beat width in bits; LINE_W SHALL be an integer multiple of BEAT_W; BEATS = LINE_W/BEAT_W >= 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pmem_read_cla  input  1  line read request from arbiter, held until pmem_resp_cla.
REQ-006 pmem_write_cla  input  1  line write request from arbiter, held until pmem_resp_cla.
REQ-007 pmem_address_cla  input  32  line address.
REQ-008 pmem_wdata_256_cla  input  LINE_W  line write data.
REQ-009 pmem_resp_cla  output  1  line transaction complete, one-cycle pulse.
REQ-010 pmem_rdata_256_cla  output  LINE_W  assembled read line.
REQ-011 mem_read  output  1  burst read to physical memory.
REQ-012 mem_write  output  1  burst write to physical memory.
REQ-013 mem_address  output  32  burst base address.
REQ-014 mem_wdata  output  BEAT_W  current write beat.
REQ-015 mem_rdata  input  BEAT_W  current read beat.
REQ-016 mem_resp  input  1  one beat accepted/returned this cycle.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE; all outputs SHALL be registered or decoded from registered state only (no input-to-output combinational path).
REQ-018 IDLE: read asserted -> latch address, go READ; else write asserted -> latch address and pmem_wdata_256_cla, go WRITE; read SHALL win if both asserted.
REQ-019 Latched address SHALL have low log2(LINE_W/8) bits forced to zero; mem_address SHALL equal it, constant for the whole burst.
REQ-020 READ/WRITE: mem_read (resp. mem_write) SHALL be held high every cycle of the state; beat counter starts at 0.
REQ-021 Each cycle with mem_resp=1 in READ: mem_rdata SHALL be stored at bits [BEAT_W*k +: BEAT_W] of the line buffer, k = beat counter, counter increments.
REQ-022 WRITE: mem_wdata SHALL present latched line bits [BEAT_W*k +: BEAT_W]; counter increments on mem_resp=1.
REQ-023 mem_resp=0 cycles SHALL stall without data or counter change (arbitrary wait states).
REQ-024 mem_resp on beat BEATS-1 SHALL move to DONE; mem_read/mem_write SHALL be low in DONE.
REQ-025 DONE: pmem_resp_cla=1 for exactly one cycle, then IDLE unconditionally; requests seen in DONE SHALL be ignored.
REQ-026 pmem_rdata_256_cla SHALL show the full line in the DONE cycle and hold it until the next READ overwrites it; WRITE SHALL not alter it.
REQ-027 Deassertion of a request mid-burst SHALL be ignored; the burst completes.
REQ-028 mem_resp in IDLE or DONE SHALL be ignored.
REQ-029 Latency with zero-wait memory: request at cycle 0 -> mem_read/mem_write high cycles 1..BEATS -> pmem_resp_cla at cycle BEATS+1 (cycle 5 at defaults).

Reset
REQ-030 rst at an edge SHALL force IDLE, beat counter 0, pmem_resp_cla=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, pmem_rdata_256_cla=0.
REQ-031 rst mid-burst SHALL abort with no pmem_resp_cla; next request starts a fresh burst at beat 0.

Verification
REQ-032 Read 0x0000_1234, mem_resp every cycle, rdata 0x11..,0x22..,0x33..,0x44.. -> mem_address=0x0000_1220, pmem_resp_cla at cycle 5, line = {0x44..,0x33..,0x22..,0x11..}.
REQ-033 Write 0x8000_0040, line {D3,D2,D1,D0}, mem_resp with 2 wait cycles before each beat -> mem_wdata D0,D1,D2,D3 in order, each held through stalls, one pmem_resp_cla pulse.
REQ-034 Read and write asserted together in IDLE -> READ burst only; mem_write never high.
REQ-035 rst after beat 2 of a read -> outputs zero next cycle, no pmem_resp_cla; new read completes with correct data.
REQ-036 Back-to-back: read line A then write immediately after resp -> pmem_rdata_256_cla stays A through write and after.
